// File: rtl/encode_function_pkg.sv
// Shared constants for the serial 8b/10b link encoder: comma words, state codes and
// the RD- forms of the 5b/6b and 3b/4b sub-block tables (bit a / bit f held in the MSB).
package encode_function_pkg;

  localparam logic [9:0] tenpos = 10'b1001111100;
  localparam logic [9:0] tenneg = 10'b0110000011;

  localparam logic [0:0] st_train = 1'b0;
  localparam logic [0:0] st_run   = 1'b1;

  // Legal control words: K28.0-7, K23.7, K27.7, K29.7, K30.7.
  function automatic logic legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hf7) || (b == 8'hfb) || (b == 8'hfd) || (b == 8'hfe);
  endfunction

  function automatic logic [5:0] code6(input logic [4:0] x, input logic k);
    logic [5:0] c;
    unique case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = k ? 6'b001111 : 6'b001110;
      5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  5'd31: c = 6'b101011;
      default: c = 6'b100111;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] code4(input logic [2:0] y, input logic k, input logic alt7);
    logic [3:0] c;
    unique case (y)
      3'd0: c = 4'b1011;
      3'd1: c = k ? 4'b0110 : 4'b1001;
      3'd2: c = k ? 4'b1010 : 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = k ? 4'b0101 : 4'b1010;
      3'd6: c = k ? 4'b1001 : 4'b0110;
      3'd7: c = (k || alt7) ? 4'b0111 : 4'b1110;
      default: c = 4'b1011;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/encode_function_encode.sv
// Combinational 8b/10b word encoder; dispin/dispout use 1 for positive disparity.
module encode_function_encode
  import encode_function_pkg::*;
(
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout,
  output logic       kerr
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k;
  logic [5:0] c6;
  logic [3:0] c4;
  logic       unbal6, unbal4, mid, alt7;

  always_comb begin
    k      = datain[8];
    x      = datain[4:0];
    y      = datain[7:5];
    kerr   = k && !legal_k(datain[7:0]);

    c6     = code6(x, k);
    unbal6 = ($countones(c6) != 3);
    if (dispin && (unbal6 || x == 5'd7)) c6 = ~c6;
    mid    = unbal6 ? ~dispin : dispin;

    // D.x.A7 avoids a run of five equal bits across the sub-block seam.
    alt7   = (!mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    c4     = code4(y, k, alt7);
    unbal4 = ($countones(c4) != 2);
    if (mid && (k || unbal4 || y == 3'd3)) c4 = ~c4;
    dispout = unbal4 ? ~mid : mid;

    // Bit a leaves the wire first, so it lands in dataout[0].
    for (int i = 0; i < 6; i++) dataout[i] = c6[5 - i];
    for (int i = 0; i < 4; i++) dataout[6 + i] = c4[3 - i];
  end

endmodule

// File: rtl/encode_function.sv
// Serial 8b/10b link transmitter: comma training after reset/retrain, then one word per
// 10-cycle slot with idle commas when the source has nothing to send.
module encode_function
  import encode_function_pkg::*;
#(
  parameter int unsigned TRAIN_WORDS = 16
) (
  input  logic       bitclk,
  input  logic       rst,
  input  logic [8:0] signal,
  input  logic       valid,
  output logic       ready,
  input  logic       train,
  output logic       sigOut,
  output logic       LinkOut,
  output logic       kerr
);

  localparam int unsigned TW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

  logic [3:0]    cnt_q;
  logic [9:0]    word_q, word_d;
  logic          rd_q, rd_d;
  logic [0:0]    state_q;
  logic [TW-1:0] tcount_q;
  logic          train_pend_q;
  logic          sig_q, kerr_q;
  logic          boundary, accept;
  logic [9:0]    enc_word;
  logic          enc_disp, enc_kerr;

  encode_function_encode u_encode (
    .datain  (signal),
    .dispin  (rd_q),
    .dataout (enc_word),
    .dispout (enc_disp),
    .kerr    (enc_kerr)
  );

  always_comb begin
    boundary = (cnt_q == 4'd9);
    ready    = (state_q == st_run) && boundary;
    accept   = ready && valid;
    // Idle fill and rejected K words both become a comma of the current polarity.
    word_d   = rd_q ? tenneg : tenpos;
    rd_d     = ~rd_q;
    if (accept && !enc_kerr) begin
      word_d = enc_word;
      rd_d   = enc_disp;
    end
  end

  always_ff @(posedge bitclk or posedge rst) begin
    if (rst) begin
      cnt_q        <= 4'd0;
      word_q       <= tenpos;
      rd_q         <= 1'b0;
      state_q      <= st_train;
      tcount_q     <= '0;
      train_pend_q <= 1'b0;
      sig_q        <= 1'b0;
      kerr_q       <= 1'b0;
    end else begin
      sig_q  <= word_q[cnt_q];
      kerr_q <= accept && enc_kerr;
      if (state_q == st_run && train) train_pend_q <= 1'b1;
      if (boundary) begin
        cnt_q        <= 4'd0;
        word_q       <= word_d;
        rd_q         <= rd_d;
        train_pend_q <= 1'b0;
        if (state_q == st_train) begin
          if (tcount_q == TW'(TRAIN_WORDS - 1)) begin
            state_q  <= st_run;
            tcount_q <= '0;
          end else begin
            tcount_q <= tcount_q + TW'(1);
          end
        end else if (train_pend_q || train) begin
          state_q  <= st_train;
          tcount_q <= '0;
        end
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign sigOut  = sig_q;
  assign LinkOut = (state_q == st_run);
  assign kerr    = kerr_q;

endmodule

// File: tb/tb_encode_function.sv
// Bench for encode_function: a slot-level link model with its own full 8b/10b tables
// predicts every serial bit plus ready, LinkOut and kerr under random traffic.
module tb_encode_function;

  logic       bitclk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] signal = '0;
  logic       valid = 1'b0;
  logic       train = 1'b0;
  logic       ready, sigOut, LinkOut, kerr;

  encode_function #(.TRAIN_WORDS(16)) dut (
    .bitclk  (bitclk),
    .rst     (rst),
    .signal  (signal),
    .valid   (valid),
    .ready   (ready),
    .train   (train),
    .sigOut  (sigOut),
    .LinkOut (LinkOut),
    .kerr    (kerr)
  );

  always #5 bitclk = ~bitclk;

  localparam logic [9:0] TENPOS = 10'b1001111100;
  localparam logic [9:0] TENNEG = 10'b0110000011;

  // Full RD-/RD+ columns, abcdei / fghj written left to right (first bit in MSB).
  logic [5:0] d6m [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
    6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
    6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
    6'b011110, 6'b101011};
  logic [5:0] d6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
    6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
    6'b011100, 6'b101000, 6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b000101, 6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
    6'b100001, 6'b010100};
  logic [3:0] d4m [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] d4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4m [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

  int n_tests = 0;
  int n_fail  = 0;
  bit q[$];
  int m_rd;
  bit m_link, m_pend, m_kerr;
  int m_trained;
  int n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", tag, got, want, n, $time);
    end
  endtask

  function automatic bit is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hf7) || (b == 8'hfb) || (b == 8'hfd) || (b == 8'hfe);
  endfunction

  function automatic int disp_after(input int rd, input int ones, input int width);
    if (2 * ones > width) return 1;
    if (2 * ones < width) return -1;
    return rd;
  endfunction

  task automatic push_comma();
    logic [9:0] c;
    c = (m_rd < 0) ? TENPOS : TENNEG;
    for (int i = 0; i < 10; i++) q.push_back(c[i]);
    m_rd = -m_rd;
  endtask

  task automatic push_encoded(input logic [8:0] s);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    x = s[4:0];
    y = s[7:5];
    if (s[8] && x == 5'd28) c6 = (m_rd < 0) ? 6'b001111 : 6'b110000;
    else c6 = (m_rd < 0) ? d6m[x] : d6p[x];
    m_rd = disp_after(m_rd, $countones(c6), 6);
    if (s[8]) c4 = (m_rd < 0) ? k4m[y] : k4p[y];
    else if (y == 3'd7 && ((m_rd < 0 && (x == 17 || x == 18 || x == 20)) ||
                           (m_rd > 0 && (x == 11 || x == 13 || x == 14))))
      c4 = (m_rd < 0) ? 4'b0111 : 4'b1000;
    else c4 = (m_rd < 0) ? d4m[y] : d4p[y];
    m_rd = disp_after(m_rd, $countones(c4), 4);
    for (int i = 5; i >= 0; i--) q.push_back(c6[i]);
    for (int i = 3; i >= 0; i--) q.push_back(c4[i]);
  endtask

  // Predicts the effect of the coming posedge from the inputs now applied.
  task automatic model_edge();
    m_kerr = 1'b0;
    if (m_link && train) m_pend = 1'b1;
    if (n % 10 == 9) begin
      if (!m_link) begin
        push_comma();
        m_trained++;
        if (m_trained == 16) begin
          m_link    = 1'b1;
          m_trained = 0;
        end
      end else begin
        if (valid && signal[8] && !is_legal_k(signal[7:0])) begin
          push_comma();
          m_kerr = 1'b1;
        end else if (valid) push_encoded(signal);
        else push_comma();
        if (m_pend) begin
          m_link    = 1'b0;
          m_trained = 0;
        end
      end
      m_pend = 1'b0;
    end
  endtask

  task automatic drive(input int mode);
    int r;
    logic [7:0] b;
    train = 1'b0;
    valid = 1'b0;
    case (mode)
      1: begin
        valid = ($urandom_range(0, 9) < 7);
        train = ($urandom_range(0, 399) == 0);
        r = int'($urandom_range(0, 19));
        if (r < 2) signal = 9'h000;
        else if (r < 4) begin
          r = int'($urandom_range(0, 11));
          if (r < 8) b = {3'(r), 5'd28};
          else if (r == 8) b = 8'hf7;
          else if (r == 9) b = 8'hfb;
          else if (r == 10) b = 8'hfd;
          else b = 8'hfe;
          signal = {1'b1, b};
        end else if (r < 5) begin
          b = 8'($urandom);
          if (is_legal_k(b)) b = 8'hff;
          signal = {1'b1, b};
        end else signal = {1'b0, 8'($urandom)};
      end
      2: begin
        valid  = 1'b1;
        signal = {1'b0, 8'($urandom)};
      end
      3: train = 1'b1;
      default: ;
    endcase
  endtask

  task automatic cycle(input int mode);
    bit b;
    @(negedge bitclk);
    n++;
    check_eq("stream_nonempty", 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      b = q.pop_front();
      check_eq("sigOut", 32'(sigOut), 32'(b));
    end
    check_eq("ready", 32'(ready), 32'(m_link && (n % 10 == 9)));
    check_eq("LinkOut", 32'(LinkOut), 32'(m_link));
    check_eq("kerr", 32'(kerr), 32'(m_kerr));
    drive(mode);
    model_edge();
  endtask

  // Called at a negedge; checks the immediate reset values, then releases.
  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    train = 1'b0;
    #1;
    check_eq("rst_sigOut", 32'(sigOut), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_LinkOut", 32'(LinkOut), 32'd0);
    check_eq("rst_kerr", 32'(kerr), 32'd0);
    repeat (3) @(negedge bitclk);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(TENPOS[i]);
    m_rd = -1; m_link = 1'b0; m_pend = 1'b0; m_kerr = 1'b0; m_trained = 0; n = 0;
    model_edge();
  endtask

  initial begin
    n = 0;
    repeat (2) @(negedge bitclk);
    do_reset();
    repeat (200) cycle(0);
    repeat (100) cycle(1);
    cycle(3);
    repeat (1500) cycle(1);
    repeat (20) cycle(2);
    for (int i = 0; i < 20; i++) begin
      if (m_link && (n % 10 == 4)) break;
      cycle(2);
    end
    check_eq("reset_point_reached", 32'(m_link && (n % 10 == 4)), 32'd1);
    do_reset();
    repeat (200) cycle(0);
    repeat (400) cycle(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
